// File: rtl/uart_mon_pkg.sv
// Shared types and constants for the UART monitor datapath.
package uart_mon_pkg;

  localparam int unsigned CH_W   = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic OP_READ = 1'b0;
  localparam logic OP_FILL = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL,
    ST_ADDR,
    ST_RD,
    ST_CAP,
    ST_WORD,
    ST_SEP,
    ST_CR,
    ST_LF,
    ST_ERR
  } state_e;

  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_QM    = 8'h3F;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  // 'a' minus 10, so that nibble 10 maps to 'a'
  localparam logic [7:0] ASC_A_M10 = 8'h57;

endpackage

// File: rtl/uart_dump_engine_if.sv
// Command bus from the monitor command parser into the dump engine.
interface uart_dump_engine_if #(
  parameter int unsigned AW = 12
);
  import uart_mon_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [CH_W-1:0]   cmd_ch;
  logic [AW-1:0]     cmd_sadr;
  logic [AW-1:0]     cmd_eadr;
  logic [DATA_W-1:0] cmd_wdata;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_sadr, cmd_eadr, cmd_wdata,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_sadr, cmd_eadr, cmd_wdata,
    output cmd_ready
  );

endinterface

// File: rtl/uart_hexchar.sv
// Nibble to lowercase ASCII hex digit.
module uart_hexchar
  import uart_mon_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] asc_o
);

  // '0'..'9' below ten, 'a'..'f' above
  always_comb begin
    asc_o = (nib_i < 4'd10) ? (ASC_ZERO + 8'(nib_i)) : (ASC_A_M10 + 8'(nib_i));
  end

endmodule

// File: rtl/uart_dump_engine.sv
// Multi-channel RAM dump/fill engine streaming ASCII hex lines to the UART.
module uart_dump_engine
  import uart_mon_pkg::*;
#(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 12,
  parameter int unsigned WPL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_dump_engine_if.slave     cmd,
  input  logic                  stop_req,
  output logic [NCH*AW-1:0]     ram_radr,
  input  logic [NCH*DATA_W-1:0] ram_rdata,
  output logic [NCH*AW-1:0]     ram_wadr,
  output logic [NCH*DATA_W-1:0] ram_wdata,
  output logic [NCH-1:0]        ram_wen,
  output logic [NCH-1:0]        read_sel,
  output logic [7:0]            send_char,
  output logic                  send_en,
  input  logic                  tx_fifo_full,
  output logic                  busy
);

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [AW-1:0]     cur_q, cur_d;
  logic [AW-1:0]     eadr_q, eadr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [3:0]        dig_q, dig_d;
  logic [3:0]        widx_q, widx_d;
  logic              more_q, more_d;
  logic              stop_q, stop_d;

  logic              emit;
  logic              rd_state;
  logic              abort;
  logic [DATA_W-1:0] rdata_sel;
  logic [DATA_W-1:0] nib_src;
  logic [3:0]        nib;
  logic [7:0]        hex_asc;

  assign busy          = (state_q != ST_IDLE);
  assign cmd.cmd_ready = (state_q == ST_IDLE) && rst_n;
  assign emit          = (state_q == ST_ADDR) || (state_q == ST_WORD) || (state_q == ST_SEP) ||
                         (state_q == ST_CR)   || (state_q == ST_LF)   || (state_q == ST_ERR);
  assign send_en       = emit && !tx_fifo_full;
  assign rd_state      = (state_q == ST_ADDR) || (state_q == ST_RD) || (state_q == ST_CAP) ||
                         (state_q == ST_WORD) || (state_q == ST_SEP);
  assign abort         = stop_req || stop_q;

  // Read data of the selected channel
  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CH_W'(k)) rdata_sel = ram_rdata[k*DATA_W +: DATA_W];
    end
  end

  // Current hex digit: byte address in ADDR, captured word in WORD, MSB nibble first
  always_comb begin
    nib_src = (state_q == ST_WORD) ? word_q : DATA_W'({cur_q, 2'b00});
    nib     = 4'(nib_src >> {3'(3'd7 - dig_q[2:0]), 2'b00});
  end

  uart_hexchar u_hex (
    .nib_i (nib),
    .asc_o (hex_asc)
  );

  // Character presented in each emitting state
  always_comb begin
    send_char = 8'h00;
    case (state_q)
      ST_ADDR: begin
        if (dig_q == 4'd8)      send_char = ASC_COLON;
        else if (dig_q == 4'd9) send_char = ASC_SP;
        else                    send_char = hex_asc;
      end
      ST_WORD: send_char = hex_asc;
      ST_SEP:  send_char = ASC_SP;
      ST_CR:   send_char = ASC_CR;
      ST_LF:   send_char = ASC_LF;
      ST_ERR:  send_char = ASC_QM;
      default: send_char = 8'h00;
    endcase
  end

  // Per-channel port slicing; only the target channel is ever non-zero
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic tgt;
    assign tgt                             = busy && (ch_q == CH_W'(k));
    assign read_sel[k]                     = tgt;
    assign ram_radr[k*AW +: AW]            = (tgt && op_q == OP_READ) ? cur_q : '0;
    assign ram_wen[k]                      = tgt && (state_q == ST_FILL) && !stop_req;
    assign ram_wadr[k*AW +: AW]            = (tgt && state_q == ST_FILL) ? cur_q : '0;
    assign ram_wdata[k*DATA_W +: DATA_W]   = (tgt && state_q == ST_FILL) ? wdata_q : '0;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ch_d    = ch_q;
    cur_d   = cur_q;
    eadr_d  = eadr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    dig_d   = dig_q;
    widx_d  = widx_q;
    more_d  = more_q;
    stop_d  = stop_q;

    // Hold an abort seen while a character is stalled
    if (rd_state && stop_req) stop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        more_d = 1'b0;
        if (cmd.cmd_valid) begin
          op_d    = cmd.cmd_op;
          ch_d    = cmd.cmd_ch;
          cur_d   = cmd.cmd_sadr;
          eadr_d  = (cmd.cmd_eadr < cmd.cmd_sadr) ? cmd.cmd_sadr : cmd.cmd_eadr;
          wdata_d = cmd.cmd_wdata;
          dig_d   = 4'd0;
          widx_d  = 4'd0;
          if (32'(cmd.cmd_ch) >= NCH)   state_d = ST_ERR;
          else if (cmd.cmd_op == OP_FILL) state_d = ST_FILL;
          else                            state_d = ST_ADDR;
        end
      end
      ST_FILL: begin
        if (stop_req || cur_q == eadr_q) state_d = ST_IDLE;
        else                             cur_d   = cur_q + AW'(1);
      end
      ST_ADDR: begin
        if (send_en) begin
          if (abort) state_d = ST_CR;
          else if (dig_q == 4'd9) begin
            dig_d   = 4'd0;
            state_d = ST_RD;
          end else dig_d = dig_q + 4'd1;
        end
      end
      ST_RD: state_d = abort ? ST_CR : ST_CAP;
      ST_CAP: begin
        if (abort) state_d = ST_CR;
        else begin
          word_d  = rdata_sel;
          dig_d   = 4'd0;
          state_d = ST_WORD;
        end
      end
      ST_WORD: begin
        if (send_en) begin
          if (abort) state_d = ST_CR;
          else if (dig_q != 4'd7) dig_d = dig_q + 4'd1;
          else begin
            dig_d = 4'd0;
            // end-of-range test precedes the increment so eadr all-ones never wraps
            if (cur_q == eadr_q) state_d = ST_CR;
            else begin
              cur_d = cur_q + AW'(1);
              if (widx_q == 4'(WPL - 1)) begin
                widx_d  = 4'd0;
                more_d  = 1'b1;
                state_d = ST_CR;
              end else begin
                widx_d  = widx_q + 4'd1;
                state_d = ST_SEP;
              end
            end
          end
        end
      end
      ST_SEP: if (send_en) state_d = abort ? ST_CR : ST_RD;
      ST_CR:  if (send_en) state_d = ST_LF;
      ST_LF: begin
        if (send_en) begin
          stop_d = 1'b0;
          if (more_q) begin
            more_d  = 1'b0;
            dig_d   = 4'd0;
            state_d = ST_ADDR;
          end else state_d = ST_IDLE;
        end
      end
      ST_ERR: if (send_en) state_d = ST_CR;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      ch_q    <= '0;
      cur_q   <= '0;
      eadr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      dig_q   <= '0;
      widx_q  <= '0;
      more_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ch_q    <= ch_d;
      cur_q   <= cur_d;
      eadr_q  <= eadr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      dig_q   <= dig_d;
      widx_q  <= widx_d;
      more_q  <= more_d;
      stop_q  <= stop_d;
    end
  end

endmodule

// File: tb/tb_uart_dump_engine.sv
// Directed and randomized bench for uart_dump_engine with a string-level line model.
module tb_uart_dump_engine;
  import uart_mon_pkg::*;

  localparam int unsigned NCH   = 2;
  localparam int unsigned AW    = 12;
  localparam int unsigned WPL   = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stop_req = 1'b0;
  logic              tx_fifo_full = 1'b0;
  logic [NCH*AW-1:0] ram_radr, ram_wadr;
  logic [NCH*32-1:0] ram_rdata, ram_wdata;
  logic [NCH-1:0]    ram_wen, read_sel;
  logic [7:0]        send_char;
  logic              send_en, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] salt;
  logic [31:0] ram_mem [int];
  logic [31:0] ref_mem [int];

  uart_dump_engine_if #(.AW(AW)) cmd_if ();

  uart_dump_engine #(.NCH(NCH), .AW(AW), .WPL(WPL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd_if),
    .stop_req     (stop_req),
    .ram_radr     (ram_radr),
    .ram_rdata    (ram_rdata),
    .ram_wadr     (ram_wadr),
    .ram_wdata    (ram_wdata),
    .ram_wen      (ram_wen),
    .read_sel     (read_sel),
    .send_char    (send_char),
    .send_en      (send_en),
    .tx_fifo_full (tx_fifo_full),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int key);
    return (32'(key) * 32'h9E3779B1) ^ salt;
  endfunction

  // RAM channels: 1-cycle read latency, background pattern until written
  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      int rkey;
      rkey = k * DEPTH + int'(ram_radr[k*AW +: AW]);
      ram_rdata[k*32 +: 32] <= ram_mem.exists(rkey) ? ram_mem[rkey] : pat(rkey);
      if (ram_wen[k] === 1'b1) ram_mem[k * DEPTH + int'(ram_wadr[k*AW +: AW])] = ram_wdata[k*32 +: 32];
    end
  end

  function automatic logic [31:0] exp_word(int ch, int a);
    int key;
    key = ch * DEPTH + a;
    return ref_mem.exists(key) ? ref_mem[key] : pat(key);
  endfunction

  // Expected character stream of a dump, truncated after char stop_at when aborting
  function automatic string exp_dump(int ch, int sa, int ea, int stop_at);
    string s;
    int a, last, w;
    a    = sa;
    last = (ea < sa) ? sa : ea;
    w    = 0;
    s    = $sformatf("%08x: ", a * 4);
    while (1) begin
      s = {s, $sformatf("%08x", exp_word(ch, a))};
      if (a == last) begin
        s = {s, "\r\n"};
        break;
      end
      a++;
      w++;
      if (w == WPL) begin
        w = 0;
        s = {s, "\r\n", $sformatf("%08x: ", a * 4)};
      end else s = {s, " "};
    end
    if (stop_at >= 0 && stop_at < s.len()) s = {s.substr(0, stop_at), "\r\n"};
    return s;
  endfunction

  function automatic string vis(string s);
    string o;
    o = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D)      o = {o, "<CR>"};
      else if (s[i] == 8'h0A) o = {o, "<LF>"};
      else                    o = {o, $sformatf("%c", s[i])};
    end
    return o;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(string tag, string obs, string exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, vis(obs), vis(exp));
    end
  endtask

  string r_got;
  int    r_wen, r_bad_sel, r_bad_w, r_bad_stall, r_bad_radr, r_first, r_to, r_cyc;

  // Issue one command and collect everything the engine does until it is idle again
  task automatic run_cmd(input logic op, input int ch, input int sa, input int ea,
                         input logic [31:0] wd, input int stall_at, input int stop_at,
                         input bit rand_bp);
    logic [NCH-1:0]    exp_sel;
    logic [NCH*AW-1:0] radr_hold;
    logic [7:0]        stall_char;
    int                stall_left, cyc;
    bit                stalled, stopped;
    stall_left = 0; cyc = 0; stalled = 0; stopped = 0;
    radr_hold = '0; stall_char = 8'h00;
    r_got = ""; r_wen = 0; r_bad_sel = 0; r_bad_w = 0; r_bad_stall = 0;
    r_bad_radr = 0; r_first = -1; r_to = 0;
    exp_sel = (ch < NCH) ? (NCH'(1) << ch) : '0;

    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_ch    = 3'(ch);
    cmd_if.cmd_sadr  = AW'(sa);
    cmd_if.cmd_eadr  = AW'(ea);
    cmd_if.cmd_wdata = wd;
    chk("cmd_ready_before_accept", 64'(cmd_if.cmd_ready), 64'd1);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;

    while (1) begin
      stop_req = (stop_at >= 0) && !stopped && (r_got.len() == stop_at);
      if (stall_at >= 0 && !stalled && r_got.len() == stall_at) begin
        stalled    = 1;
        stall_left = 5;
      end
      tx_fifo_full = (stall_left > 0) || (rand_bp && $urandom_range(0, 2) == 0);
      #1;
      if (busy !== 1'b1) break;
      if (read_sel !== exp_sel) r_bad_sel++;
      if (tx_fifo_full && send_en !== 1'b0) r_bad_stall++;
      if (stall_left > 0) begin
        if (stall_left == 5) stall_char = send_char;
        else if (send_char !== stall_char) r_bad_stall++;
        stall_left--;
      end
      if (stopped && ram_radr !== radr_hold) r_bad_radr++;
      if (stop_req) begin
        stopped   = 1;
        radr_hold = ram_radr;
      end
      if (send_en === 1'b1) begin
        r_got = {r_got, $sformatf("%c", send_char)};
        if (r_first < 0) r_first = cyc;
      end
      if (ram_wen !== '0) begin
        if (ram_wen !== exp_sel || ram_wadr[ch*AW +: AW] !== AW'(sa + r_wen) ||
            ram_wdata[ch*32 +: 32] !== wd) r_bad_w++;
        if (r_first < 0) r_first = cyc;
        r_wen++;
      end
      cyc++;
      if (cyc > 3000) begin
        r_to = 1;
        break;
      end
      @(negedge clk);
    end
    stop_req     = 1'b0;
    tx_fifo_full = 1'b0;
    r_cyc        = cyc;
    chk("done_in_budget", 64'(r_to), 64'd0);
  endtask

  int          ch, sa, ea, n;
  logic [31:0] wd;
  string       ex;

  initial begin
    salt             = $urandom;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_READ;
    cmd_if.cmd_ch    = '0;
    cmd_if.cmd_sadr  = '0;
    cmd_if.cmd_eadr  = '0;
    cmd_if.cmd_wdata = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("in_reset_outputs", 64'({cmd_if.cmd_ready, busy, send_en, send_char, read_sel, ram_wen}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_if.cmd_ready), 64'd1);
    chk("reset_outputs", 64'({busy, send_en, send_char, read_sel, ram_wen, |ram_radr, |ram_wadr, |ram_wdata}), 64'd0);

    // Single-word fill then the reference single-word dump
    run_cmd(OP_FILL, 1, 4, 4, 32'hDEADBEEF, -1, -1, 0);
    ref_mem[1 * DEPTH + 4] = 32'hDEADBEEF;
    chk("fill1_wen_count", 64'(r_wen), 64'd1);
    chk("fill1_write_bus", 64'(r_bad_w), 64'd0);
    chk_s("fill1_no_chars", r_got, "");
    run_cmd(OP_READ, 1, 4, 4, 32'h0, -1, -1, 0);
    chk_s("read1_text", r_got, "00000010: deadbeef\r\n");
    chk("read1_char_count", 64'(r_got.len()), 64'd20);
    chk("read1_read_sel", 64'(r_bad_sel), 64'd0);
    chk("read1_first_char_latency", 64'(r_first), 64'd0);
    chk("read1_ready_after", 64'(cmd_if.cmd_ready), 64'd1);

    // Two-line dump 0..5
    run_cmd(OP_READ, 0, 0, 5, 32'h0, -1, -1, 0);
    chk_s("read2_stream", r_got, exp_dump(0, 0, 5, -1));
    chk_s("read2_line2_prefix", r_got.substr(47, 55), "00000010:");

    // Fill at the top of the address space
    run_cmd(OP_FILL, 0, 'hFFE, 'hFFF, 32'h12345678, -1, -1, 0);
    ref_mem[0 * DEPTH + 'hFFE] = 32'h12345678;
    ref_mem[0 * DEPTH + 'hFFF] = 32'h12345678;
    chk("fill2_wen_count", 64'(r_wen), 64'd2);
    chk("fill2_write_bus", 64'(r_bad_w), 64'd0);
    chk("fill2_busy_cycles", 64'(r_cyc), 64'd2);
    chk("fill2_first_write_latency", 64'(r_first), 64'd0);
    chk_s("fill2_no_chars", r_got, "");
    chk("fill2_no_wrap_write", 64'(ram_mem.exists(0)), 64'd0);
    run_cmd(OP_READ, 0, 'hFFE, 'hFFF, 32'h0, -1, -1, 0);
    chk_s("read_top_text", r_got, "00003ff8: 12345678 12345678\r\n");

    // Backpressure for five cycles mid-word
    run_cmd(OP_READ, 1, 'h10, 'h13, 32'h0, 14, -1, 0);
    chk_s("stall_stream", r_got, exp_dump(1, 'h10, 'h13, -1));
    chk("stall_char_hold", 64'(r_bad_stall), 64'd0);

    // End before start collapses to the start word
    run_cmd(OP_READ, 0, 'h20, 'h10, 32'h0, -1, -1, 0);
    chk_s("reversed_range", r_got, exp_dump(0, 'h20, 'h10, -1));

    // Abort on the third digit of the first word of a 16-word dump
    run_cmd(OP_READ, 1, 'h100, 'h10F, 32'h0, -1, 12, 0);
    chk_s("stop_stream", r_got, exp_dump(1, 'h100, 'h10F, 12));
    chk("stop_radr_frozen", 64'(r_bad_radr), 64'd0);
    chk("stop_idle", 64'({busy, cmd_if.cmd_ready}), 64'd1);

    // Randomized commands with random backpressure
    for (int i = 0; i < 8; i++) begin
      ch = int'($urandom_range(0, NCH - 1));
      sa = int'($urandom_range(0, DEPTH - 1));
      n  = int'($urandom_range(1, 9));
      ea = (sa + n - 1 > DEPTH - 1) ? DEPTH - 1 : sa + n - 1;
      if ($urandom_range(0, 2) == 0) begin
        wd = $urandom;
        run_cmd(OP_FILL, ch, sa, ea, wd, -1, -1, 0);
        for (int a = sa; a <= ea; a++) ref_mem[ch * DEPTH + a] = wd;
        chk("rand_fill_count", 64'(r_wen), 64'(ea - sa + 1));
        chk("rand_fill_bus", 64'(r_bad_w), 64'd0);
      end else begin
        ex = exp_dump(ch, sa, ea, -1);
        run_cmd(OP_READ, ch, sa, ea, 32'h0, -1, -1, 1);
        chk_s("rand_read_stream", r_got, ex);
        chk("rand_read_backpressure", 64'(r_bad_stall), 64'd0);
      end
    end

    // Out-of-range channel
    run_cmd(OP_READ, 5, 0, 0, 32'h0, -1, -1, 0);
    chk_s("err_stream", r_got, "?\r\n");
    chk("err_read_sel", 64'(r_bad_sel), 64'd0);
    chk("err_no_write", 64'(r_wen), 64'd0);

    // Reset in the middle of a long fill
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_FILL;
    cmd_if.cmd_ch    = 3'd0;
    cmd_if.cmd_sadr  = AW'(0);
    cmd_if.cmd_eadr  = AW'('h3F);
    cmd_if.cmd_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midfill_active", 64'({busy, ram_wen}), 64'b101);
    rst_n = 1'b0;
    #1;
    chk("midfill_reset_outputs",
        64'({busy, cmd_if.cmd_ready, send_en, send_char, read_sel, ram_wen, |ram_radr, |ram_wadr, |ram_wdata}),
        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_idle", 64'({cmd_if.cmd_ready, busy, send_en}), 64'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
